// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: opcodes, FSM states,
// ALU controls, datapath select encodings and small combinational helpers.
package cpu_mc_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_SLL = 6'h00;
   localparam logic [5:0] F_SRL = 6'h02;
   localparam logic [5:0] F_SRA = 6'h03;
   localparam logic [5:0] F_JR  = 6'h08;
   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_XOR = 6'h26;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASS_B
   } alu_ctrl_t;

   typedef enum logic [1:0] {IMM_SIGN, IMM_ZERO, IMM_LUI} imm_kind_t;
   typedef enum logic [2:0] {PC_HOLD, PC_INC, PC_JUMP, PC_JR, PC_BRANCH, PC_TRAP} pc_sel_t;
   typedef enum logic [1:0] {DEST_RT, DEST_RD, DEST_RA} dest_sel_t;
   typedef enum logic [1:0] {WB_ALU, WB_MDR, WB_PC} wb_sel_t;

   typedef struct packed {
      alu_ctrl_t alu_ctrl;
      logic      alu_src_imm;
      imm_kind_t imm_kind;
      logic      ir_load;
      logic      ab_load;
      logic      alu_out_load;
      logic      mdr_load;
      logic      rf_we;
      dest_sel_t dest_sel;
      wb_sel_t   wb_sel;
      pc_sel_t   pc_sel;
      logic      mem_write;
   } ctrl_t;

   function automatic logic inst_legal(input logic [5:0] op, input logic [5:0] funct);
      logic ok;
      case (op)
         OP_RTYPE: begin
            case (funct)
               F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLL, F_SRL, F_SRA, F_JR: ok = 1'b1;
               default: ok = 1'b0;
            endcase
         end
         OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI,
         OP_XORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Shifts operate on the B operand (rt), matching MIPS sll/srl/sra.
   function automatic logic [31:0] alu_calc(input alu_ctrl_t ctrl, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] shamt);
      logic [31:0] y;
      case (ctrl)
         ALU_ADD:    y = a + b;
         ALU_SUB:    y = a - b;
         ALU_AND:    y = a & b;
         ALU_OR:     y = a | b;
         ALU_XOR:    y = a ^ b;
         ALU_SLL:    y = b << shamt;
         ALU_SRL:    y = b >> shamt;
         ALU_SRA:    y = $signed(b) >>> shamt;
         ALU_PASS_B: y = b;
         default:    y = a + b;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/cpu_mc_control.sv
// FSM and instruction decode for the multi-cycle core; produces datapath
// enables, mux selects and the next state used to register memory outputs.
module cpu_mc_control
   import cpu_mc_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] ir,
   input  logic        mem_done,
   input  logic        ab_equal,
   output state_t      state,
   output state_t      next_state,
   output ctrl_t       ctrl
);

   logic [5:0] op_s;
   logic [5:0] funct_s;
   logic       is_rtype_s;
   alu_ctrl_t  alu_ctrl_s;
   imm_kind_t  imm_kind_s;

   assign op_s       = ir[31:26];
   assign funct_s    = ir[5:0];
   assign is_rtype_s = (op_s == OP_RTYPE);

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_FETCH;
      end else begin
         state <= next_state;
      end
   end

   // ALU operation and immediate extension implied by the instruction
   always_comb begin
      alu_ctrl_s = ALU_ADD;
      imm_kind_s = IMM_SIGN;
      case (op_s)
         OP_RTYPE: begin
            case (funct_s)
               F_SUB:   alu_ctrl_s = ALU_SUB;
               F_AND:   alu_ctrl_s = ALU_AND;
               F_OR:    alu_ctrl_s = ALU_OR;
               F_XOR:   alu_ctrl_s = ALU_XOR;
               F_SLL:   alu_ctrl_s = ALU_SLL;
               F_SRL:   alu_ctrl_s = ALU_SRL;
               F_SRA:   alu_ctrl_s = ALU_SRA;
               default: alu_ctrl_s = ALU_ADD;
            endcase
         end
         OP_ANDI: begin alu_ctrl_s = ALU_AND;    imm_kind_s = IMM_ZERO; end
         OP_ORI:  begin alu_ctrl_s = ALU_OR;     imm_kind_s = IMM_ZERO; end
         OP_XORI: begin alu_ctrl_s = ALU_XOR;    imm_kind_s = IMM_ZERO; end
         OP_LUI:  begin alu_ctrl_s = ALU_PASS_B; imm_kind_s = IMM_LUI;  end
         OP_BEQ, OP_BNE: alu_ctrl_s = ALU_SUB;
         default: alu_ctrl_s = ALU_ADD;
      endcase
   end

   // Next-state and per-state control outputs
   always_comb begin
      next_state     = state;
      ctrl           = '0;
      ctrl.alu_ctrl  = alu_ctrl_s;
      ctrl.imm_kind  = imm_kind_s;
      ctrl.mem_write = (op_s == OP_SW);
      case (state)
         ST_FETCH: begin
            if (mem_done) begin
               ctrl.ir_load = 1'b1;
               ctrl.pc_sel  = PC_INC;
               next_state   = ST_DECODE;
            end else begin
               ctrl.pc_sel  = PC_HOLD;
            end
         end
         ST_DECODE: begin
            ctrl.ab_load = 1'b1;
            if (!inst_legal(op_s, funct_s)) begin
               next_state = ST_TRAP;
            end else if (op_s == OP_J) begin
               ctrl.pc_sel = PC_JUMP;
               next_state  = ST_FETCH;
            end else if (op_s == OP_JAL) begin
               ctrl.rf_we    = 1'b1;
               ctrl.dest_sel = DEST_RA;
               ctrl.wb_sel   = WB_PC;
               ctrl.pc_sel   = PC_JUMP;
               next_state    = ST_FETCH;
            end else if (is_rtype_s && (funct_s == F_JR)) begin
               ctrl.pc_sel = PC_JR;
               next_state  = ST_FETCH;
            end else begin
               next_state  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            ctrl.alu_out_load = 1'b1;
            ctrl.alu_src_imm  = !is_rtype_s;
            if ((op_s == OP_BEQ) || (op_s == OP_BNE)) begin
               if (ab_equal ^ (op_s == OP_BNE)) begin
                  ctrl.pc_sel = PC_BRANCH;
               end else begin
                  ctrl.pc_sel = PC_HOLD;
               end
               next_state = ST_FETCH;
            end else if ((op_s == OP_LW) || (op_s == OP_SW)) begin
               next_state = ST_MEM;
            end else begin
               next_state = ST_WB;
            end
         end
         ST_MEM: begin
            if (mem_done) begin
               if (op_s == OP_SW) begin
                  next_state = ST_FETCH;
               end else begin
                  ctrl.mdr_load = 1'b1;
                  next_state    = ST_WB;
               end
            end else begin
               next_state = ST_MEM;
            end
         end
         ST_WB: begin
            ctrl.rf_we    = 1'b1;
            ctrl.dest_sel = is_rtype_s ? DEST_RD : DEST_RT;
            ctrl.wb_sel   = (op_s == OP_LW) ? WB_MDR : WB_ALU;
            next_state    = ST_FETCH;
         end
         ST_TRAP: begin
            ctrl.pc_sel = PC_TRAP;
            next_state  = ST_FETCH;
         end
         default: next_state = ST_FETCH;
      endcase
   end

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle MIPS-subset core with one shared req/ready memory port.
// Holds the datapath, 32x32 register file and ALU; control lives in cpu_mc_control.
module cpu_multicycle
   import cpu_mc_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          PC_STEP     = 4,
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
   input  logic        clock,
   input  logic        reset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] pc,
   output logic [2:0]  state,
   output logic        trap
);

   localparam logic [31:0] PC_STEP_W = 32'(PC_STEP);

   logic [31:0] ir_r, a_r, b_r, alu_out_r, mdr_r;
   logic [31:0] rf_r [32];

   state_t      state_s, next_state_s;
   ctrl_t       ctrl_s;
   logic        mem_done_s;
   logic [4:0]  rs_s, rt_s, dest_s;
   logic [31:0] rs_val_s, rt_val_s, imm_sext_s, imm_ext_s, alu_b_s, alu_res_s;
   logic [31:0] pc_next_s, wb_data_s;

   assign mem_done_s = mem_req & mem_ready;
   assign rs_s       = ir_r[25:21];
   assign rt_s       = ir_r[20:16];
   assign rs_val_s   = (rs_s == 5'd0) ? 32'h0 : rf_r[rs_s];
   assign rt_val_s   = (rt_s == 5'd0) ? 32'h0 : rf_r[rt_s];
   assign imm_sext_s = {{16{ir_r[15]}}, ir_r[15:0]};
   assign alu_b_s    = ctrl_s.alu_src_imm ? imm_ext_s : b_r;
   assign alu_res_s  = alu_calc(ctrl_s.alu_ctrl, a_r, alu_b_s, ir_r[10:6]);
   assign state      = state_s;

   cpu_mc_control u_control (
      .clock      (clock),
      .reset      (reset),
      .ir         (ir_r),
      .mem_done   (mem_done_s),
      .ab_equal   (a_r == b_r),
      .state      (state_s),
      .next_state (next_state_s),
      .ctrl       (ctrl_s)
   );

   // Immediate extension
   always_comb begin
      imm_ext_s = imm_sext_s;
      case (ctrl_s.imm_kind)
         IMM_SIGN: imm_ext_s = imm_sext_s;
         IMM_ZERO: imm_ext_s = {16'h0000, ir_r[15:0]};
         IMM_LUI:  imm_ext_s = {ir_r[15:0], 16'h0000};
         default:  imm_ext_s = imm_sext_s;
      endcase
   end

   // Next PC; branch target is relative to the already-incremented pc
   always_comb begin
      pc_next_s = pc;
      case (ctrl_s.pc_sel)
         PC_HOLD:   pc_next_s = pc;
         PC_INC:    pc_next_s = pc + PC_STEP_W;
         PC_JUMP:   pc_next_s = {pc[31:28], ir_r[25:0], 2'b00};
         PC_JR:     pc_next_s = rs_val_s;
         PC_BRANCH: pc_next_s = pc + (imm_sext_s * PC_STEP_W);
         PC_TRAP:   pc_next_s = TRAP_VECTOR;
         default:   pc_next_s = pc;
      endcase
   end

   // Register-file write destination and data
   always_comb begin
      dest_s    = rt_s;
      wb_data_s = alu_out_r;
      case (ctrl_s.dest_sel)
         DEST_RT: dest_s = rt_s;
         DEST_RD: dest_s = ir_r[15:11];
         DEST_RA: dest_s = 5'd31;
         default: dest_s = rt_s;
      endcase
      case (ctrl_s.wb_sel)
         WB_ALU:  wb_data_s = alu_out_r;
         WB_MDR:  wb_data_s = mdr_r;
         WB_PC:   wb_data_s = pc;
         default: wb_data_s = alu_out_r;
      endcase
   end

   // Datapath registers, PC and register file
   always_ff @(posedge clock) begin
      if (reset) begin
         ir_r      <= 32'h0;
         a_r       <= 32'h0;
         b_r       <= 32'h0;
         alu_out_r <= 32'h0;
         mdr_r     <= 32'h0;
         pc        <= RESET_PC;
         for (int i = 0; i < 32; i++) begin
            rf_r[i] <= 32'h0;
         end
      end else begin
         if (ctrl_s.ir_load)      ir_r      <= mem_rdata;
         if (ctrl_s.ab_load)      a_r       <= rs_val_s;
         if (ctrl_s.ab_load)      b_r       <= rt_val_s;
         if (ctrl_s.alu_out_load) alu_out_r <= alu_res_s;
         if (ctrl_s.mdr_load)     mdr_r     <= mem_rdata;
         pc <= pc_next_s;
         if (ctrl_s.rf_we && (dest_s != 5'd0)) begin
            rf_r[dest_s] <= wb_data_s;
         end
      end
   end

   // Memory port and trap pulse registered from the upcoming state, so a
   // request is held steady until ready and withdrawn right after it completes
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         trap      <= 1'b0;
      end else begin
         trap <= (next_state_s == ST_TRAP);
         if (next_state_s == ST_FETCH) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc_next_s;
         end else if (next_state_s == ST_MEM) begin
            mem_req   <= 1'b1;
            mem_we    <= ctrl_s.mem_write;
            mem_addr  <= (state_s == ST_EXEC) ? alu_res_s : alu_out_r;
            mem_wdata <= b_r;
         end else begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: a small program in a wait-state memory
// model, with hand-computed register, memory, PC and latency expectations.
module tb_cpu_multicycle;

   logic        clock = 1'b0;
   logic        reset;
   logic        mem_req, mem_we, mem_ready, trap;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
   logic [2:0]  state;

   logic [31:0] mem [256];
   int          checks = 0;
   int          failures = 0;
   int          wcnt = 0;
   int          data_waits = 2;
   bit          hold_ready = 1'b0;
   logic [31:0] held_addr, held_wdata, orig_word3;
   int          n;

   always #5 clock = ~clock;

   cpu_multicycle #(
      .RESET_PC    (32'h0000_0000),
      .PC_STEP     (4),
      .TRAP_VECTOR (32'h0000_0080)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .pc        (pc),
      .state     (state),
      .trap      (trap)
   );

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One clock: drive ready/rdata from the memory model, verify a pending
   // request is held steady, then commit any write after the edge.
   task automatic step();
      logic       do_wr;
      logic [7:0] widx;
      logic [31:0] wval;
      int         cur;
      cur = (state == 3'd3) ? data_waits : 0;
      mem_ready = !hold_ready && (!mem_req || (wcnt >= cur));
      mem_rdata = mem[mem_addr[9:2]];
      if (mem_req && (wcnt == 0)) begin
         held_addr  = mem_addr;
         held_wdata = mem_wdata;
      end else if (mem_req) begin
         check_eq("hold_addr", mem_addr, held_addr);
         check_eq("hold_wdata", mem_wdata, held_wdata);
      end
      do_wr = mem_req && mem_we && mem_ready && !reset;
      widx  = mem_addr[9:2];
      wval  = mem_wdata;
      if (reset || (mem_req && mem_ready)) wcnt = 0;
      else if (mem_req) wcnt++;
      @(posedge clock);
      @(negedge clock);
      if (do_wr) mem[widx] = wval;
   endtask

   task automatic wait_fetch(input logic [31:0] addr, output int cycles);
      cycles = 0;
      while (!((mem_req === 1'b1) && (mem_we === 1'b0) && (mem_addr === addr)) && (cycles < 40)) begin
         step();
         cycles++;
      end
   endtask

   initial begin
      reset = 1'b1;
      mem_ready = 1'b1;
      mem_rdata = 32'h0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h00] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);        // addi r1,r0,5
      mem[8'h01] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);     // addi r2,r0,-3
      mem[8'h02] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);   // add  r3,r1,r2
      mem[8'h03] = enc_r(5'd2, 5'd1, 5'd4, 5'd0, 6'h22);   // sub  r4,r2,r1
      mem[8'h04] = enc_i(6'h04, 5'd1, 5'd1, 16'd2);        // beq  r1,r1,+2
      mem[8'h05] = enc_i(6'h08, 5'd0, 5'd7, 16'd1);        // skipped
      mem[8'h06] = enc_i(6'h08, 5'd0, 5'd7, 16'd2);        // skipped
      mem[8'h07] = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);        // sw   r3,8(r0)
      mem[8'h08] = {6'h03, 26'h40};                        // jal  0x40
      mem[8'h09] = enc_r(5'd0, 5'd1, 5'd8, 5'd2, 6'h00);   // sll  r8,r1,2
      mem[8'h0A] = enc_i(6'h0F, 5'd0, 5'd9, 16'h1234);     // lui  r9,0x1234
      mem[8'h0B] = enc_i(6'h0D, 5'd9, 5'd9, 16'hF00F);     // ori  r9,r9,0xF00F
      mem[8'h0C] = 32'hFC00_0000;                          // illegal opcode 3F
      mem[8'h20] = enc_i(6'h2B, 5'd0, 5'd1, 16'd12);       // sw   r1,12(r0)
      mem[8'h40] = enc_i(6'h23, 5'd0, 5'd5, 16'd8);        // lw   r5,8(r0)
      mem[8'h41] = enc_r(5'd0, 5'd2, 5'd10, 5'd1, 6'h03);  // sra  r10,r2,1
      mem[8'h42] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);  // jr   r31

      // Reset held 3 cycles with ready high
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("rst_req", {31'h0, mem_req}, 32'h0);
      end
      check_eq("rst_pc", pc, 32'h0);
      check_eq("rst_state", {29'h0, state}, 32'h0);
      check_eq("rst_trap", {31'h0, trap}, 32'h0);
      reset = 1'b0;
      step();
      check_eq("first_req", {31'h0, mem_req}, 32'h1);
      check_eq("first_addr", mem_addr, 32'h0);
      check_eq("first_we", {31'h0, mem_we}, 32'h0);

      // ALU instructions, 4 cycles each
      wait_fetch(32'h04, n); check_eq("addi1_cyc", n, 32'd4); check_eq("r1", dut.rf_r[1], 32'd5);
      wait_fetch(32'h08, n); check_eq("addi2_cyc", n, 32'd4); check_eq("r2", dut.rf_r[2], 32'hFFFF_FFFD);
      wait_fetch(32'h0C, n); check_eq("add_cyc", n, 32'd4);   check_eq("r3", dut.rf_r[3], 32'd2);
      wait_fetch(32'h10, n); check_eq("sub_cyc", n, 32'd4);   check_eq("r4", dut.rf_r[4], 32'hFFFF_FFF8);

      // Taken branch, then store with 2 wait states
      wait_fetch(32'h1C, n); check_eq("beq_cyc", n, 32'd3);
      wait_fetch(32'h20, n); check_eq("sw_cyc", n, 32'd6);    check_eq("mem8", mem[2], 32'd2);

      // jal, load with 2 wait states, sra, jr
      wait_fetch(32'h100, n); check_eq("jal_cyc", n, 32'd2);
      check_eq("jal_pc", pc, 32'h100);
      check_eq("r31", dut.rf_r[31], 32'h24);
      wait_fetch(32'h104, n); check_eq("lw_cyc", n, 32'd7);   check_eq("r5", dut.rf_r[5], 32'd2);
      wait_fetch(32'h108, n); check_eq("sra_cyc", n, 32'd4);  check_eq("r10", dut.rf_r[10], 32'hFFFF_FFFE);
      wait_fetch(32'h24, n);  check_eq("jr_cyc", n, 32'd2);   check_eq("jr_pc", pc, 32'h24);
      wait_fetch(32'h28, n);  check_eq("r8", dut.rf_r[8], 32'h14);
      wait_fetch(32'h2C, n);  check_eq("r9_lui", dut.rf_r[9], 32'h1234_0000);
      wait_fetch(32'h30, n);  check_eq("r9_ori", dut.rf_r[9], 32'h1234_F00F);
      check_eq("r7_skipped", dut.rf_r[7], 32'h0);

      // Illegal opcode traps
      step();
      step();
      check_eq("trap_pulse", {31'h0, trap}, 32'h1);
      check_eq("trap_state", {29'h0, state}, 32'd5);
      step();
      check_eq("trap_clear", {31'h0, trap}, 32'h0);
      check_eq("trap_pc", pc, 32'h80);
      check_eq("trap_fetch", mem_addr, 32'h80);
      check_eq("trap_req", {31'h0, mem_req}, 32'h1);

      // Reset during a stalled store, ready rising on the reset edge
      orig_word3 = mem[3];
      step();
      step();
      step();
      hold_ready = 1'b1;
      step();
      step();
      check_eq("stall_state", {29'h0, state}, 32'd3);
      check_eq("stall_we", {31'h0, mem_we}, 32'h1);
      check_eq("stall_addr", mem_addr, 32'd12);
      reset = 1'b1;
      hold_ready = 1'b0;
      data_waits = 0;
      step();
      check_eq("mrst_req", {31'h0, mem_req}, 32'h0);
      check_eq("mrst_we", {31'h0, mem_we}, 32'h0);
      check_eq("mrst_state", {29'h0, state}, 32'h0);
      check_eq("mrst_pc", pc, 32'h0);
      check_eq("mrst_mem", mem[3], orig_word3);
      check_eq("mrst_r1", dut.rf_r[1], 32'h0);
      reset = 1'b0;
      step();
      check_eq("mrst_refetch", mem_addr, 32'h0);
      check_eq("mrst_rereq", {31'h0, mem_req}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
